axi_tdd_sync_monitor: RTL and testbench

Receive-side counterpart of the TDD sync generator. It takes the sync pulse train produced by a sync generator, which may come from another device or FPGA. It checks each pulse against the expected period, declares lock, and regenerates a clean `sync_out` with flywheel pulses when input syncs go missing. It sits between the external sync pin and the TDD controller's sync input.

---
 rtl/axi_tdd_sync_monitor.sv | 187 ++++++++++++++++++
 tb/tb_axi_tdd_sync_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_sync_monitor.sv
// Receive-side TDD sync monitor: checks incoming sync pulses against the expected
// period, declares lock, and regenerates sync_out with flywheel pulses across dropouts.
module axi_tdd_sync_monitor #(
   parameter int SYNC_EXTERNAL_CDC = 0,
   parameter int SYNC_COUNT_WIDTH  = 64,
   parameter int TOL_WIDTH         = 8,
   parameter int LOCK_COUNT        = 4,
   parameter int MISS_LIMIT        = 3
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        sync_in,
   input  logic                        tdd_enable,
   input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_period,
   input  logic [TOL_WIDTH-1:0]        asy_tdd_sync_tolerance,
   output logic                        sync_out,
   output logic                        sync_locked,
   output logic                        sync_lost,
   output logic [7:0]                  sync_miss_count,
   output logic [SYNC_COUNT_WIDTH-1:0] sync_period_meas
);
   localparam int W = SYNC_COUNT_WIDTH;
   localparam logic [7:0] LOCK_CNT = 8'(LOCK_COUNT);
   localparam logic [7:0] MISS_LIM = 8'(MISS_LIMIT);

   typedef enum logic [1:0] {IDLE, SEARCH, TRACK, HOLDOVER} state_t;

   state_t           state_reg, state_next;
   logic [W-1:0]     cnt_reg, cnt_next, p_reg, p_next, meas_reg, meas_next;
   logic [TOL_WIDTH-1:0] t_reg, t_next;
   logic [7:0]       good_reg, good_next, miss_run_reg, miss_run_next;
   logic [7:0]       miss_cnt_reg, miss_cnt_next;
   logic             seeded_reg, seeded_next, out_reg, out_next;
   logic             locked_reg, locked_next, lost_reg, lost_next;
   logic             ev;

   generate
      if (SYNC_EXTERNAL_CDC != 0) begin : g_cdc
         logic [2:0] sync_pipe;
         always_ff @(posedge clk) begin
            if (!resetn) sync_pipe <= '0;
            else         sync_pipe <= {sync_pipe[1:0], sync_in};
         end
         assign ev = sync_pipe[1] & ~sync_pipe[2];
      end else begin : g_direct
         assign ev = sync_in;
      end
   endgenerate

   // Window arithmetic is done one bit wider so P+T cannot wrap.
   logic [W:0]   p_ext, t_ext, cnt1, lo, hi_sum, hi;
   logic [W-1:0] cnt_inc, meas_val, t_cnt;
   logic [7:0]   miss_inc;
   logic         p_valid, in_win, at_close;

   always_comb begin
      p_ext    = {1'b0, p_reg};
      t_ext    = {{(W+1-TOL_WIDTH){1'b0}}, t_reg};
      cnt1     = {1'b0, cnt_reg} + 1'b1;
      lo       = (p_ext > t_ext) ? (p_ext - t_ext) : {{W{1'b0}}, 1'b1};
      hi_sum   = p_ext + t_ext;
      hi       = hi_sum[W] ? {1'b0, {W{1'b1}}} : hi_sum;
      in_win   = (cnt1 >= lo) && (cnt1 <= hi);
      at_close = (cnt1 >= hi);
      p_valid  = (p_reg >= W'(2));
      cnt_inc  = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
      meas_val = cnt1[W] ? {W{1'b1}} : cnt1[W-1:0];
      t_cnt    = {{(W-TOL_WIDTH){1'b0}}, t_reg};
      miss_inc = (miss_cnt_reg == 8'hFF) ? 8'hFF : miss_cnt_reg + 8'd1;
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_inc;
      p_next        = p_reg;
      t_next        = t_reg;
      seeded_next   = seeded_reg;
      good_next     = good_reg;
      miss_run_next = miss_run_reg;
      out_next      = 1'b0;
      lost_next     = lost_reg;
      miss_cnt_next = miss_cnt_reg;
      meas_next     = meas_reg;
      if (!tdd_enable) begin
         state_next    = IDLE;
         cnt_next      = '0;
         lost_next     = 1'b0;
         miss_cnt_next = '0;
         good_next     = '0;
         miss_run_next = '0;
         seeded_next   = 1'b0;
      end else begin
         p_next = asy_tdd_sync_period;
         t_next = asy_tdd_sync_tolerance;
         case (state_reg)
            IDLE: begin
               state_next = SEARCH;
               cnt_next   = '0;
            end
            SEARCH: begin
               out_next = ev;
               if (ev) begin
                  if (seeded_reg) begin
                     meas_next = meas_val;
                     good_next = in_win ? good_reg + 8'd1 : 8'd0;
                     if (in_win && (good_reg + 8'd1 >= LOCK_CNT)) begin
                        state_next    = TRACK;
                        miss_run_next = '0;
                     end
                  end
                  seeded_next = 1'b1;
                  cnt_next    = '0;
               end
            end
            TRACK, HOLDOVER: begin
               if (ev && in_win) begin
                  out_next      = 1'b1;
                  meas_next     = meas_val;
                  cnt_next      = '0;
                  miss_run_next = '0;
                  state_next    = TRACK;
               end else if (at_close) begin
                  // Flywheel lands T late; reloading cnt with T restores nominal phase.
                  out_next      = 1'b1;
                  cnt_next      = t_cnt;
                  miss_cnt_next = miss_inc;
                  miss_run_next = miss_run_reg + 8'd1;
                  if (miss_run_reg + 8'd1 >= MISS_LIM) begin
                     state_next  = SEARCH;
                     lost_next   = 1'b1;
                     seeded_next = 1'b0;
                     good_next   = '0;
                  end else begin
                     state_next = HOLDOVER;
                  end
               end else if (ev) begin
                  miss_cnt_next = miss_inc;
               end
            end
            default: state_next = IDLE;
         endcase
         if (state_reg != IDLE && !p_valid) begin
            state_next  = SEARCH;
            out_next    = ev;
            seeded_next = 1'b0;
            good_next   = '0;
         end
      end
      locked_next = tdd_enable && (state_next == TRACK || state_next == HOLDOVER);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         p_reg        <= '0;
         t_reg        <= '0;
         seeded_reg   <= 1'b0;
         good_reg     <= '0;
         miss_run_reg <= '0;
         out_reg      <= 1'b0;
         locked_reg   <= 1'b0;
         lost_reg     <= 1'b0;
         miss_cnt_reg <= '0;
         meas_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         p_reg        <= p_next;
         t_reg        <= t_next;
         seeded_reg   <= seeded_next;
         good_reg     <= good_next;
         miss_run_reg <= miss_run_next;
         out_reg      <= out_next;
         locked_reg   <= locked_next;
         lost_reg     <= lost_next;
         miss_cnt_reg <= miss_cnt_next;
         meas_reg     <= meas_next;
      end
   end

   assign sync_out         = out_reg;
   assign sync_locked      = locked_reg;
   assign sync_lost        = lost_reg;
   assign sync_miss_count  = miss_cnt_reg;
   assign sync_period_meas = meas_reg;
endmodule

// File: tb/tb_axi_tdd_sync_monitor.sv
// Scoreboard bench for axi_tdd_sync_monitor: stimulus queues each expected sync_out
// with its cycle and status outputs; a negedge monitor pops and compares.
module tb_axi_tdd_sync_monitor;
   logic        clk, resetn, sync_in, sync_in_c, tdd_enable;
   logic [63:0] period;
   logic [7:0]  tol;
   logic        sync_out, sync_locked, sync_lost;
   logic [7:0]  sync_miss_count;
   logic [63:0] sync_period_meas;
   logic        sync_out_c, sync_locked_c, sync_lost_c;
   logic [7:0]  sync_miss_count_c;
   logic [63:0] sync_period_meas_c;

   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   typedef struct {
      int unsigned cyc;
      logic        locked;
      logic        lost;
      logic [7:0]  miss;
      logic [63:0] meas;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   axi_tdd_sync_monitor #(.SYNC_EXTERNAL_CDC(0)) dut (
      .clk(clk), .resetn(resetn), .sync_in(sync_in), .tdd_enable(tdd_enable),
      .asy_tdd_sync_period(period), .asy_tdd_sync_tolerance(tol),
      .sync_out(sync_out), .sync_locked(sync_locked), .sync_lost(sync_lost),
      .sync_miss_count(sync_miss_count), .sync_period_meas(sync_period_meas)
   );

   axi_tdd_sync_monitor #(.SYNC_EXTERNAL_CDC(1)) dut_cdc (
      .clk(clk), .resetn(resetn), .sync_in(sync_in_c), .tdd_enable(tdd_enable),
      .asy_tdd_sync_period(period), .asy_tdd_sync_tolerance(tol),
      .sync_out(sync_out_c), .sync_locked(sync_locked_c), .sync_lost(sync_lost_c),
      .sync_miss_count(sync_miss_count_c), .sync_period_meas(sync_period_meas_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int unsigned c, input logic lk, input logic ls,
                             input logic [7:0] m, input logic [63:0] me);
      exp_t e;
      e.cyc = c; e.locked = lk; e.lost = ls; e.miss = m; e.meas = me;
      q.push_back(e);
   endtask

   task automatic pulse_at(input int unsigned k);
      while (cyc < k) tick();
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sync_out"}, 64'(sync_out), 0);
      chk({tag, "_locked"}, 64'(sync_locked), 0);
      chk({tag, "_lost"}, 64'(sync_lost), 0);
      chk({tag, "_miss"}, 64'(sync_miss_count), 0);
      chk({tag, "_meas"}, sync_period_meas, 0);
   endtask

   always @(negedge clk) begin
      if (q.size() != 0 && q[0].cyc < cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL missing_sync_out: required at cyc %0d, still absent at cyc %0d", q[0].cyc, cyc);
         void'(q.pop_front());
      end
      if (sync_out) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_sync_out: got pulse at cyc %0d, required none", cyc);
         end else begin
            mon_e = q.pop_front();
            $display("[TB] sync_out cyc=%0d locked=%0d lost=%0d miss=%0d meas=%0d",
                     cyc, sync_locked, sync_lost, sync_miss_count, sync_period_meas);
            chk("sync_out_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("sync_locked", 64'(sync_locked), 64'(mon_e.locked));
            chk("sync_lost", 64'(sync_lost), 64'(mon_e.lost));
            chk("sync_miss_count", 64'(sync_miss_count), 64'(mon_e.miss));
            chk("sync_period_meas", sync_period_meas, mon_e.meas);
         end
      end
   end

   initial begin
      int unsigned b, d, f, k, t;
      int n;
      resetn = 1'b0; tdd_enable = 1'b0; sync_in = 1'b0; sync_in_c = 1'b0;
      period = 64'd100; tol = 8'd2;
      repeat (3) tick();
      chk_all_zero("reset");
      resetn = 1'b1; tdd_enable = 1'b1;
      tick(); tick();

      // Asynchronous level step: exactly one regenerated pulse within 4 edges of sampling.
      k = cyc; n = 0; t = 0;
      sync_in_c = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sync_out_c) begin
            n++;
            if (n == 1) t = cyc;
         end
      end
      $display("[TB] cdc step at cyc=%0d pulses=%0d first=%0d", k, n, t);
      chk("cdc_pulse_count", 64'(n), 1);
      chk("cdc_latency_in_range", 64'((t >= k + 2) && (t <= k + 5)), 1);

      // Lock acquisition: seed, then four in-window periods.
      b = cyc + 10;
      for (int i = 0; i < 5; i++)
         expect_out(b + 100*i + 1, (i == 4), 1'b0, 8'd0, (i == 0) ? 64'd0 : 64'd100);
      for (int i = 0; i < 5; i++) pulse_at(b + 100*i);
      expect_out(b + 501, 1, 0, 8'd0, 64'd100); pulse_at(b + 500);

      // Single dropout: flywheel 102 after the previous output, then nominal pulse accepted.
      expect_out(b + 603, 1, 0, 8'd1, 64'd100);
      expect_out(b + 701, 1, 0, 8'd1, 64'd100); pulse_at(b + 700);

      // Spurious pulse at cnt+1=50 dropped; window edges 102 and 98 accepted.
      pulse_at(b + 750);
      expect_out(b + 801, 1, 0, 8'd2, 64'd100); pulse_at(b + 800);
      expect_out(b + 903, 1, 0, 8'd2, 64'd102); pulse_at(b + 902);
      expect_out(b + 1001, 1, 0, 8'd2, 64'd98); pulse_at(b + 1000);

      // Loss of lock after three flywheels, then plain forwarding.
      expect_out(b + 1103, 1, 0, 8'd3, 64'd98);
      expect_out(b + 1203, 1, 0, 8'd4, 64'd98);
      expect_out(b + 1303, 0, 1, 8'd5, 64'd98);
      expect_out(b + 1401, 0, 1, 8'd5, 64'd98); pulse_at(b + 1400);
      expect_out(b + 1451, 0, 1, 8'd5, 64'd50); pulse_at(b + 1450);

      // Disable with a coincident pulse: pulse ignored, status cleared, measurement kept.
      while (cyc < b + 1470) tick();
      tdd_enable = 1'b0; sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      chk("disable_lost", 64'(sync_lost), 0);
      chk("disable_miss", 64'(sync_miss_count), 0);
      chk("disable_locked", 64'(sync_locked), 0);
      chk("disable_meas_kept", sync_period_meas, 64'd50);
      tdd_enable = 1'b1;
      tick(); tick();

      // Relock, then reset in the middle of a tracked period.
      d = cyc + 5;
      for (int i = 0; i < 5; i++)
         expect_out(d + 100*i + 1, (i == 4), 1'b0, 8'd0, (i == 0) ? 64'd50 : 64'd100);
      for (int i = 0; i < 5; i++) pulse_at(d + 100*i);
      while (cyc < d + 450) tick();
      chk("pre_reset_locked", 64'(sync_locked), 1);
      resetn = 1'b0; period = 64'd1;
      tick();
      chk_all_zero("midtrack_reset");
      resetn = 1'b1;
      tick(); tick(); tick();

      // Invalid period: pulses mirrored, never locked, nothing measured.
      f = cyc + 3;
      for (int i = 0; i < 4; i++) expect_out(f + 10*i + 1, 0, 0, 8'd0, 64'd0);
      for (int i = 0; i < 4; i++) pulse_at(f + 10*i);
      repeat (5) tick();
      chk("invalid_p_locked", 64'(sync_locked), 0);
      chk("queue_drained", 64'(q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
